gf180mcu_fd_sc_mcu9t5v0__decap_seq: RTL

- Sequenced enable controller for switched decap/filler-cap segments on the 9-track 5V0 supply rails.
- Answers a power-request handshake by switching NSEG capacitor segments on one at a time, then off in reverse order, with a programmable dwell between steps to limit inrush and rail droop.
- Sits between the block power manager (request side) and the switched-cap segment array (enable side).

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__decap_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__decap_seq.sv
// gf180mcu_fd_sc_mcu9t5v0__decap_seq
//
// Sequenced enable controller for the switched decap segments on the
// 9-track 5V0 rails. It answers a level power request by switching NSEG
// capacitor segments on one at a time, bit 0 first. When the request drops,
// it switches them off in reverse order. A programmable dwell between steps
// limits inrush current and rail droop.
//
// Parameters:
//   NSEG  - number of switched segments (1..32)
//   DW    - width of DWELL and of the dwell counter
//
// Ports:
//   CLK     in   rising-edge clock
//   RST     in   synchronous reset, active-high
//   REQ     in   level request (1 = caps on, 0 = caps off)
//   DWELL   in   cycles between steps minus one, sampled on each counter reload
//   SEG_EN  out  thermometer-coded segment enables
//   ACK     out  all segments on and settled
//   BUSY    out  ramp (up or down) in progress
//   SEG_CNT out  popcount of SEG_EN (only with GF180MCU_FD_SC_MCU9T5V0_DECAP_SEQ_CNT_EN)
//   VDD/VSS inout supply and ground pass-through for the cell view
//
// Optional feature macro: GF180MCU_FD_SC_MCU9T5V0_DECAP_SEQ_CNT_EN
//   When this macro is defined, the SEG_CNT output and its register are
//   added. When it is undefined, that port and logic are absent.

module gf180mcu_fd_sc_mcu9t5v0__decap_seq #(
  parameter int NSEG = 8,
  parameter int DW   = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ,
  input  logic [DW-1:0]   DWELL,
  output logic [NSEG-1:0] SEG_EN,
  output logic            ACK,
  output logic            BUSY,
`ifdef GF180MCU_FD_SC_MCU9T5V0_DECAP_SEQ_CNT_EN
  output logic [$clog2(NSEG+1)-1:0] SEG_CNT,
`endif
  inout  wire             VDD,
  inout  wire             VSS
);

  localparam int CW = $clog2(NSEG + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RAMP_UP = 2'd1;
  localparam logic [1:0] ON      = 2'd2;
  localparam logic [1:0] RAMP_DN = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [NSEG-1:0] seg_d;
  logic            seg_full, seg_empty;

  // The supply pins carry no logic; they are only referenced so the netlist keeps them.
  wire unused_rails = VDD ^ VSS;

  // SEG_EN is always a thermometer code. Its top bit therefore means "full",
  // and its bottom bit means "not empty".
  assign seg_full  = SEG_EN[NSEG-1];
  assign seg_empty = ~SEG_EN[0];

  function automatic logic [CW-1:0] popcount(input logic [NSEG-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < NSEG; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  // Next-state logic. A step (set or clear one segment) happens only when
  // the dwell counter has run down to zero. Every step reloads the counter
  // from DWELL, so a new DWELL value only takes effect at the next reload.
  // A request reversal mid-ramp turns the ramp around without moving a
  // segment. It also restarts the dwell, so that the segments of the
  // reversed ramp are still spaced DWELL+1 cycles apart.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seg_d   = SEG_EN;
    case (state_q)
      IDLE: begin
        if (REQ) begin
          seg_d   = NSEG'(1);
          cnt_d   = DWELL;
          state_d = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (!REQ) begin
          cnt_d   = DWELL;
          state_d = RAMP_DN;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DW'(1);
        end else if (!seg_full) begin
          seg_d = (SEG_EN << 1) | NSEG'(1);
          cnt_d = DWELL;
        end else begin
          state_d = ON;
        end
      end
      ON: begin
        // Leaving ON removes the top segment immediately, so the first
        // ramp-down step happens on the same edge on which ACK falls.
        if (!REQ) begin
          seg_d   = SEG_EN >> 1;
          cnt_d   = DWELL;
          state_d = RAMP_DN;
        end
      end
      RAMP_DN: begin
        if (REQ) begin
          cnt_d   = DWELL;
          state_d = RAMP_UP;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DW'(1);
        end else if (!seg_empty) begin
          seg_d = SEG_EN >> 1;
          cnt_d = DWELL;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        seg_d   = '0;
      end
    endcase
  end

  // State and output registers. ACK and BUSY are decoded from the next state,
  // so they change on the same edge as the state they describe. Reset drops
  // all segments at once, with no ramp-down.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      SEG_EN  <= '0;
      ACK     <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      SEG_EN  <= seg_d;
      ACK     <= (state_d == ON);
      BUSY    <= (state_d == RAMP_UP) || (state_d == RAMP_DN);
    end
  end

`ifdef GF180MCU_FD_SC_MCU9T5V0_DECAP_SEQ_CNT_EN
  // The segment count is registered from the next enable vector, so it
  // always matches SEG_EN in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      SEG_CNT <= '0;
    end else begin
      SEG_CNT <= popcount(seg_d);
    end
  end
`endif

endmodule
